ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
Synthesizable AHB slave backed by a flop-based word memory. It is the responder end for ahb_master and the synthesizable counterpart of the behavioural slave model. It decodes address/data phases, handles byte, halfword and word writes with lane strobes, and inserts programmable plus externally forced wait states. It issues the two-cycle ERROR response for out-of-range or illegal-size transfers. It sits behind the interconnect decoder (i_hsel) and the hready mux (i_hready).

Parameters:
DATA_WDT, 32, data bus width in bits; legal values 32 or 64.
DEPTH, 256, memory depth in DATA_WDT-bit words; power of two.
WAIT_CYCLES, 0, fixed wait states inserted per accepted NONSEQ/SEQ transfer; range 0..15.

Ports:
i_hclk  in  1  clock, rising edge.
i_hreset_n  in  1  asynchronous active-low reset.
i_hsel  in  1  slave select from the address decoder.
i_haddr  in  32  transfer address.
i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
i_hwrite  in  1  1 = write.
i_hsize  in  3  transfer size, encoded as log2 of bytes.
i_hburst  in  3  burst type; informational only, not decoded.
i_hwdata  in  DATA_WDT  write data, valid in the data phase.
i_hready  in  1  bus-level hready; qualifies the address phase.
i_stall  in  1  verification/backpressure hook; adds one wait state per cycle it is high during a data phase.
o_hrdata  out  DATA_WDT  read data.
o_hready  out  1  this slave's ready.
o_hresp  out  2  OKAY=0, ERROR=1; RETRY and SPLIT are never issued.

Behaviour:
- Reset values (asynchronous): o_hready=1, o_hresp=OKAY, o_hrdata=0, state=IDLE, wait counter=0. Memory array is not reset.
- Address phase accept: i_hsel & i_hready & i_htrans[1]. On accept, latch haddr, hwrite and hsize into data-phase registers.
- Illegal transfer: address >= DEPTH*DATA_WDT/8, or hsize > log2(DATA_WDT/8).
- Word index = haddr[log2(DATA_WDT/8) +: log2(DEPTH)].
- IDLE/BUSY, or i_hsel=0 with i_hready=1: the next cycle is a zero-wait OKAY with no memory access.
- States:
  - IDLE: no pending data phase. o_hready=1, o_hresp=OKAY.
    - Accepted legal transfer with WAIT_CYCLES=0 and i_stall=0 goes to DATA.
    - Accepted legal transfer with WAIT_CYCLES>0 goes to WAIT.
    - Accepted illegal transfer goes to ERR1.
  - WAIT: o_hready=0, o_hresp=OKAY. Counter loads WAIT_CYCLES-1 and decrements. At 0 with i_stall=0, go to DATA.
  - DATA: final data-phase cycle. o_hready=1 unless i_stall=1; if i_stall=1, hold o_hready=0 and stay in DATA.
    - Write with o_hready=1: the rising edge that ends the cycle updates the memory lanes selected by the strobe.
    - Read: o_hrdata = mem[index_q], combinational from the array.
    - Next state is chosen from the concurrent address phase, exactly as from IDLE; otherwise go to IDLE.
  - ERR1: o_hready=0, o_hresp=ERROR. Unconditionally go to ERR2.
  - ERR2: o_hready=1, o_hresp=ERROR, no memory access. A concurrent address phase is accepted as from IDLE. i_stall is ignored in ERR1 and ERR2.
- Byte strobes (little-endian):
  - Byte: one lane, haddr[log2-1:0].
  - Halfword: two lanes, aligned down.
  - Word: four lanes.
  - Doubleword (64-bit bus only): all lanes.
  - Misaligned addresses are aligned down silently; this is not an error.
- o_hrdata = 0 whenever the slave is not in a read DATA cycle.
- Write followed by a read of the same address, back to back: the read sees the new data. This follows from the write committing before the read's data phase.
- Pipelining: a new address phase may overlap any cycle where o_hready=1; the slave is never blind to it.
- Reset asserted mid-transfer: asynchronous return to IDLE with reset output values. Any pending write is dropped; memory contents are retained.
- i_hburst is ignored; wrap and increment address generation is the master's responsibility.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans enum (IDLE, BUSY, NONSEQ, SEQ).
  - hresp enum (OKAY, ERROR, RETRY, SPLIT).
  - hsize constants (BYTE=0, HALF=1, WORD=2, DWORD=3).
  - hburst enum.
  - The slave state enum (IDLE, WAIT, DATA, ERR1, ERR2).
- One sub-module, ahb_slave_lane_dec: inputs haddr low bits and hsize; output a DATA_WDT/8-bit strobe plus an illegal-size flag. It is shared with future slaves.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF word @0x10, then read @0x10 -> o_hready never low; read data phase returns 0xDEADBEEF; o_hresp=OKAY throughout.
- Byte writes 0x11 @0x20, 0x22 @0x21, halfword 0x4433 @0x22 -> word read @0x20 returns 0x44332211.
- WAIT_CYCLES=3, i_stall pulsed high 2 cycles in the data phase -> o_hready low exactly 5 cycles, then a single high cycle.
- Read @0x400 with DEPTH=256 (32-bit bus) -> ERR1 (hready=0, resp=1) then ERR2 (hready=1, resp=1); memory untouched; a NONSEQ issued during ERR2 completes OKAY.
- ahb_master burst of 20 beats with random i_dav (BUSY insertion) -> BUSY beats return zero-wait OKAY with no write; all 20 words read back in order.
- Assert i_hreset_n low during a WAIT state of a write -> o_hready=1, o_hresp=OKAY immediately; the target word keeps its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and slave FSM state codes used by the AHB slave family.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Slave FSM state codes kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle: address/data phase inputs and the slave response.
interface ahb_slave_mem_if #(
  parameter int DATA_WDT = 32
);
  logic                i_hsel;
  logic [31:0]         i_haddr;
  logic [1:0]          i_htrans;
  logic                i_hwrite;
  logic [2:0]          i_hsize;
  logic [2:0]          i_hburst;
  logic [DATA_WDT-1:0] i_hwdata;
  logic                i_hready;
  logic [DATA_WDT-1:0] o_hrdata;
  logic                o_hready;
  logic [1:0]          o_hresp;

  modport master (
    output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    input  o_hrdata, o_hready, o_hresp
  );

  modport slave (
    input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst, i_hwdata, i_hready,
    output o_hrdata, o_hready, o_hresp
  );
endinterface

// File: rtl/ahb_slave_lane_dec.sv
// Byte-lane strobe decoder: little-endian lanes for a transfer size, misaligned
// addresses aligned down; flags sizes wider than the bus.
module ahb_slave_lane_dec
  import ahb_pkg::*;
#(
  parameter int DATA_WDT = 32,
  localparam int NB = DATA_WDT / 8,
  localparam int AW = $clog2(NB)
) (
  input  logic [AW-1:0] haddr_lo,
  input  logic [2:0]    hsize,
  output logic [NB-1:0] strb,
  output logic          size_err
);

  localparam logic [2:0] MAX_SIZE = 3'(AW);

  assign size_err = (hsize > MAX_SIZE);

  // A lane is enabled when it falls in the same size-aligned block as the address.
  for (genvar g = 0; g < NB; g++) begin : g_lane
    localparam logic [AW-1:0] LANE = AW'(g);
    assign strb[g] = !size_err && ((LANE >> hsize) == (haddr_lo >> hsize));
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave backed by a flop word memory, with programmable and forced wait
// states and a two-cycle ERROR response for out-of-range or oversized transfers.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DATA_WDT    = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic            i_hclk,
  input logic            i_hreset_n,
  input logic            i_stall,
  ahb_slave_mem_if.slave bus
);

  localparam int NB = DATA_WDT / 8;
  localparam int AW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [2:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                open_p0, accept_p0, addr_err_p0, size_err_p0;
  logic [NB-1:0]       strb_p0;
  logic [IW-1:0]       index_p1;
  logic                hwrite_p1;
  logic [NB-1:0]       strb_p1;
  logic                wr_en;
  logic [DATA_WDT-1:0] mem [DEPTH];
  logic                unused_bus;

  assign unused_bus = ^{bus.i_hburst, bus.i_htrans[0]};

  // Address phase (p0): decode and qualify the incoming transfer.
  ahb_slave_lane_dec #(.DATA_WDT(DATA_WDT)) u_lane_dec (
    .haddr_lo (bus.i_haddr[AW-1:0]),
    .hsize    (bus.i_hsize),
    .strb     (strb_p0),
    .size_err (size_err_p0)
  );

  assign addr_err_p0 = |(bus.i_haddr >> (AW + IW));
  assign open_p0     = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                       ((state_q == ST_DATA) && !i_stall);
  assign accept_p0   = open_p0 && bus.i_hsel && bus.i_hready && bus.i_htrans[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if ((state_q == ST_DATA) && i_stall) begin
          state_d = ST_DATA;
        end else if (accept_p0) begin
          if (addr_err_p0 || size_err_p0) begin
            state_d = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // A stall cycle freezes the countdown so each one adds exactly one wait.
      ST_WAIT: begin
        if (!i_stall) begin
          if (cnt_q == 4'd0) state_d = ST_DATA;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data phase (p1): transfer attributes captured at address-phase accept.
  always_ff @(posedge i_hclk) begin
    if (accept_p0) begin
      index_p1  <= bus.i_haddr[AW +: IW];
      hwrite_p1 <= bus.i_hwrite;
      strb_p1   <= strb_p0;
    end
  end

  assign wr_en = (state_q == ST_DATA) && !i_stall && hwrite_p1;

  always_ff @(posedge i_hclk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_p1[b]) mem[index_p1][8*b +: 8] <= bus.i_hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    bus.o_hready = !((state_q == ST_WAIT) || (state_q == ST_ERR1) ||
                     ((state_q == ST_DATA) && i_stall));
    bus.o_hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    bus.o_hrdata = ((state_q == ST_DATA) && !hwrite_p1) ? mem[index_p1] : '0;
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: a zero-wait instance and a three-wait instance.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall0, stall3;
  int          checks = 0;
  int          failures = 0;
  int          lows, first_hi, waits;
  logic        got;
  logic [31:0] rd, nd;
  logic [31:0] exp_burst [20];

  always #5 clk = ~clk;

  ahb_slave_mem_if #(.DATA_WDT(32)) b0 ();
  ahb_slave_mem_if #(.DATA_WDT(32)) b3 ();

  assign b0.i_hready = b0.o_hready;
  assign b3.i_hready = b3.o_hready;

  ahb_slave_mem #(.DATA_WDT(32), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_stall(stall0), .bus(b0.slave));
  ahb_slave_mem #(.DATA_WDT(32), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_stall(stall3), .bus(b3.slave));

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ap0(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a);
    b0.i_hsel = sel; b0.i_htrans = tr; b0.i_hwrite = wr; b0.i_hsize = sz; b0.i_haddr = a;
  endtask

  task automatic ap3(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] a);
    b3.i_hsel = sel; b3.i_htrans = tr; b3.i_hwrite = wr; b3.i_hsize = sz; b3.i_haddr = a;
  endtask

  initial begin
    rst_n = 1'b0; stall0 = 1'b0; stall3 = 1'b0;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    ap3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    b0.i_hburst = HBURST_INCR; b3.i_hburst = HBURST_SINGLE;
    b0.i_hwdata = 32'h0; b3.i_hwdata = 32'h0;

    // Reset values
    smp;
    chk("rst_hready0", 32'(b0.o_hready), 32'd1);
    chk("rst_hresp0",  32'(b0.o_hresp),  32'd0);
    chk("rst_hrdata0", b0.o_hrdata,      32'h0);
    chk("rst_hready3", 32'(b3.o_hready), 32'd1);
    nxt; nxt;
    rst_n = 1'b1;

    // Word write then back-to-back read, zero wait
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    smp; chk("t1_ap_hready", 32'(b0.o_hready), 32'd1); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10); b0.i_hwdata = 32'hDEADBEEF;
    smp; chk("t1_wr_hready", 32'(b0.o_hready), 32'd1); chk("t1_wr_hresp", 32'(b0.o_hresp), 32'd0); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b0.i_hwdata = 32'h0;
    smp; chk("t1_rd_hready", 32'(b0.o_hready), 32'd1); chk("t1_rd_data", b0.o_hrdata, 32'hDEADBEEF);
    chk("t1_rd_hresp", 32'(b0.o_hresp), 32'd0); nxt;
    smp; chk("t1_idle_rdata", b0.o_hrdata, 32'h0); nxt;

    // Byte and halfword lane strobes
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h20); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h21); b0.i_hwdata = 32'hFFFFFF11; nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22); b0.i_hwdata = 32'hFFFF22FF; nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20); b0.i_hwdata = 32'h4433FFFF;
    smp; chk("t2_hready", 32'(b0.o_hready), 32'd1); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b0.i_hwdata = 32'h0;
    smp; chk("t2_rd_data", b0.o_hrdata, 32'h44332211); nxt;

    // Misaligned halfword aligns down
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h31); b0.i_hwdata = 32'h01020304; nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30); b0.i_hwdata = 32'hAAAA5566; nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b0.i_hwdata = 32'h0;
    smp; chk("t3_misalign", b0.o_hrdata, 32'h01025566); nxt;

    // BUSY and unselected transfers do not write
    ap0(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10); nxt;
    ap0(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    smp; chk("t4_busy_hready", 32'(b0.o_hready), 32'd1); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    smp; chk("t4_nosel_hready", 32'(b0.o_hready), 32'd1); chk("t4_nosel_rdata", b0.o_hrdata, 32'h0); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t4_rd_data", b0.o_hrdata, 32'hDEADBEEF); nxt;

    // Out-of-range write: ERR1, ERR2 with overlapped read
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h410); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t5_err1_hready", 32'(b0.o_hready), 32'd0); chk("t5_err1_hresp", 32'(b0.o_hresp), 32'd1); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    smp; chk("t5_err2_hready", 32'(b0.o_hready), 32'd1); chk("t5_err2_hresp", 32'(b0.o_hresp), 32'd1); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t5_rd_hresp", 32'(b0.o_hresp), 32'd0); chk("t5_rd_hready", 32'(b0.o_hready), 32'd1);
    chk("t5_rd_data", b0.o_hrdata, 32'hDEADBEEF); nxt;

    // Oversized transfer on a 32-bit bus
    ap0(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 32'h10); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t6_err1_hresp", 32'(b0.o_hresp), 32'd1); chk("t6_err1_hready", 32'(b0.o_hready), 32'd0); nxt;
    smp; chk("t6_err2_hresp", 32'(b0.o_hresp), 32'd1); chk("t6_err2_hready", 32'(b0.o_hready), 32'd1); nxt;
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10); nxt;
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t6_rd_data", b0.o_hrdata, 32'hDEADBEEF); nxt;

    // 20-beat write burst with BUSY slots, then pipelined readback
    for (int i = 0; i < 20; i++) exp_burst[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    nd = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 2) begin
        ap0(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h100 + 32'(4 * (i - 1)));
        b0.i_hwdata = nd; nd = 32'hBAD0BAD0;
        smp; chk("t7_busy_hready", 32'(b0.o_hready), 32'd1); nxt;
      end
      ap0(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'h100 + 32'(4 * i));
      b0.i_hwdata = nd; nd = exp_burst[i];
      smp; chk("t7_wr_hready", 32'(b0.o_hready), 32'd1); nxt;
    end
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b0.i_hwdata = nd; nxt;
    b0.i_hwdata = 32'h0;
    for (int i = 0; i < 20; i++) begin
      ap0(1'b1, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h100 + 32'(4 * i));
      smp;
      if (i > 0) chk("t7_rd_data", b0.o_hrdata, exp_burst[i-1]);
      nxt;
    end
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t7_rd_last", b0.o_hrdata, exp_burst[19]); nxt;

    // Three programmed waits plus two stall cycles
    ap3(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40);
    smp; chk("t8_ap_hready", 32'(b3.o_hready), 32'd1); nxt;
    ap3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b3.i_hwdata = 32'hCAFEF00D;
    lows = 0; first_hi = -1;
    for (int k = 0; k < 10; k++) begin
      stall3 = (k < 2);
      smp;
      if (!b3.o_hready) lows++;
      else if (first_hi < 0) first_hi = k;
      chk("t8_hresp", 32'(b3.o_hresp), 32'd0);
      nxt;
    end
    stall3 = 1'b0;
    chk("t8_low_cycles", 32'(lows), 32'd5);
    chk("t8_first_high", 32'(first_hi), 32'd5);

    ap3(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40); nxt;
    ap3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    got = 1'b0; waits = 0; rd = 32'h0;
    for (int k = 0; k < 10; k++) begin
      smp;
      if (!got) begin
        if (b3.o_hready) begin got = 1'b1; rd = b3.o_hrdata; end
        else waits++;
      end
      nxt;
    end
    chk("t8_rd_done", 32'(got), 32'd1);
    chk("t8_rd_waits", 32'(waits), 32'd3);
    chk("t8_rd_data", rd, 32'hCAFEF00D);

    // Reset during a write wait state drops the write
    ap3(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h40); nxt;
    ap3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0); b3.i_hwdata = 32'h12345678;
    smp; chk("t9_wait_hready", 32'(b3.o_hready), 32'd0);
    #1 rst_n = 1'b0;
    #1 chk("t9_rst_hready", 32'(b3.o_hready), 32'd1); chk("t9_rst_hresp", 32'(b3.o_hresp), 32'd0);
    nxt; nxt;
    rst_n = 1'b1;
    nxt; nxt; nxt; nxt;
    ap3(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
    ap0(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10); nxt;
    ap3(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    ap0(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
    smp; chk("t9_u0_retained", b0.o_hrdata, 32'hDEADBEEF);
    got = 1'b0; rd = 32'h0;
    for (int k = 0; k < 10; k++) begin
      smp;
      if (!got && b3.o_hready) begin got = 1'b1; rd = b3.o_hrdata; end
      nxt;
    end
    chk("t9_rd_done", 32'(got), 32'd1);
    chk("t9_rd_data", rd, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
